apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Round-robin scheduler that shares one APB master command port between NREQ local requesters.
- Accepts one request at a time, drives the master's CMD/SADDR/WDATA, and watches the APB bus for completion.
- Returns read data and a completion pulse to the granted requester.
- A timeout counter aborts transfers whose slave never asserts PREADY.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, max cycles in BUSY before abort (>=2).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous reset, active high.
- req  in  NREQ  per-requester request level; held until gnt.
- req_write  in  NREQ  1=write, 0=read, per requester.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data, same packing.
- gnt  out  NREQ  one-hot, 1-cycle pulse: request accepted and captured.
- done  out  NREQ  one-hot, 1-cycle pulse: transfer finished.
- err  out  1  valid with done; 1 = aborted by timeout.
- rdata  out  DW  read data; valid with done on a read.
- M_CMD  out  2  command to master: 00 NOP, 01 read, 10 write.
- M_SADDR  out  AW  address to master.
- M_WDATA  out  DW  write data to master.
- M_PSEL  in  1  bus PSEL, observed.
- M_PENABLE  in  1  bus PENABLE, observed.
- M_PREADY  in  1  bus PREADY, observed.
- M_PRDATA  in  DW  bus PRDATA, observed.

Behaviour:

Reset (PRESET=1, async):
- state=IDLE; gnt=0, done=0, err=0.
- rdata, M_SADDR, M_WDATA = 0; M_CMD=NOP.
- Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- Timeout counter = 0.

Outputs and state:
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, BUSY, GAP.

IDLE:
- If any req bit is set, the winner is the first set bit searching last+1, last+2, ... with wrap modulo NREQ.
- At the next edge:
  - gnt[win]=1 for one cycle; last=win.
  - Capture M_SADDR=req_addr[win] and M_WDATA=req_wdata[win].
  - M_CMD = 10 if req_write[win], else 01.
  - Counter cleared; state=BUSY.
- With no request, M_CMD stays NOP.

BUSY:
- M_CMD, M_SADDR and M_WDATA are held stable.
- Completion is a rising edge where M_PSEL & M_PENABLE & M_PREADY.
- On completion:
  - done[win]=1 and err=0.
  - rdata=M_PRDATA for a read; rdata holds for a write.
  - M_CMD=NOP; state=GAP.
- Otherwise the counter increments.
- If no completion has occurred when the counter reaches TIMEOUT-1:
  - done[win]=1, err=1, rdata unchanged.
  - M_CMD=NOP; state=GAP.
- Completion on the same edge as timeout: completion wins, err=0.

GAP:
- One cycle with M_CMD=NOP so the master returns to idle; then state=IDLE.
- No arbitration happens in GAP. Minimum spacing from one gnt to the next is 4 cycles with a zero-wait slave.

Request-line rules:
- req may deassert after gnt without effect.
- A requester deasserting req before gnt simply loses arbitration.
- The granted requester's req is ignored until done.
- Requests from other requesters are held off, never dropped: they are sampled again in IDLE.

Latency:
- req visible in IDLE -> gnt one edge later.
- done is 1 edge after the completing PREADY cycle.

Reset mid-transfer:
- Everything returns to reset values immediately; no done is issued.
- A bus transfer in flight is abandoned; the master is reset by the same system reset.

Test Plan:
1. Single read: req=0001, req_addr[0]=0x0000_0040, slave PREADY in the first ACCESS cycle with PRDATA=0xDEAD_BEEF -> gnt=0001, M_CMD=01, M_SADDR=0x40, then done=0001, err=0, rdata=0xDEAD_BEEF, M_CMD=NOP.
2. Round-robin: req=1111 held, each requester re-raises after its done -> grant order 0,1,2,3,0; no requester is granted twice while another waits.
3. Write with wait states: req[2] write, addr=0x100, wdata=0x1234_5678, PREADY low for 3 ACCESS cycles -> M_WDATA and M_CMD=10 stable throughout BUSY; done[2] one cycle after PREADY; rdata unchanged.
4. Timeout: TIMEOUT=16, PREADY never asserted -> done[win]=1 and err=1 exactly 16 cycles after entering BUSY, then GAP, then IDLE; the next request is served normally.
5. Simultaneous completion and timeout: PREADY asserted on the counter=TIMEOUT-1 edge -> err=0, rdata captured.
6. Reset in BUSY: assert PRESET while the transfer is in ACCESS -> all outputs to reset values asynchronously; no done pulse; after release, req=0010 is granted to requester 0 if it also requests (pointer restored to NREQ-1).

Source files
------------

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Purpose:
//   Shares one APB master command port between NREQ local requesters using
//   round-robin arbitration. One request is accepted at a time. The selected
//   command is driven to the master. Completion is detected by watching the
//   APB bus. A timeout aborts transfers whose slave never asserts PREADY.
//
// Ports:
//   PCLK, PRESET       clock; asynchronous active-high reset
//   req                per-requester request level, held until gnt
//   req_write          per-requester direction (1 = write, 0 = read)
//   req_addr/req_wdata packed per-requester address / write data
//   gnt                one-hot pulse: request accepted and captured
//   done               one-hot pulse: transfer finished
//   err                valid with done; 1 = aborted by timeout
//   rdata              read data, valid with done on a read
//   M_CMD              command to the master (00 NOP, 01 read, 10 write)
//   M_SADDR/M_WDATA    address / write data to the master
//   M_PSEL/M_PENABLE/M_PREADY/M_PRDATA  observed APB bus signals
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic [DW-1:0]     rdata,
    output logic [1:0]        M_CMD,
    output logic [AW-1:0]     M_SADDR,
    output logic [DW-1:0]     M_WDATA,
    input  logic              M_PSEL,
    input  logic              M_PENABLE,
    input  logic              M_PREADY,
    input  logic [DW-1:0]     M_PRDATA
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_GAP
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_last;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_err;
    logic [DW-1:0]   r_rdata;
    logic [1:0]      r_cmd;
    logic [AW-1:0]   r_saddr;
    logic [DW-1:0]   r_wdata;

    logic            w_any;
    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_cand;
    logic            w_complete;

    // Round-robin search: first set req bit after the last winner, with wrap.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_any   = |req;
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_last} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            w_cand = w_sum[PW-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // A completed APB access: ACCESS phase with the slave ready.
    assign w_complete = M_PSEL & M_PENABLE & M_PREADY;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
            r_last  <= PW'(NREQ - 1);
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_cmd   <= CMD_NOP;
            r_saddr <= '0;
            r_wdata <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            r_gnt  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt[w_win] <= 1'b1;
                        r_last       <= w_win;
                        r_saddr      <= req_addr[w_win*AW +: AW];
                        r_wdata      <= req_wdata[w_win*DW +: DW];
                        r_cmd        <= req_write[w_win] ? CMD_WR : CMD_RD;
                        r_cnt        <= '0;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Completion is checked first so it wins over a
                    // coincident timeout.
                    if (w_complete) begin
                        r_done[r_last] <= 1'b1;
                        if (r_cmd == CMD_RD) begin
                            r_rdata <= M_PRDATA;
                        end
                        r_cmd   <= CMD_NOP;
                        r_state <= ST_GAP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_done[r_last] <= 1'b1;
                        r_err          <= 1'b1;
                        r_cmd          <= CMD_NOP;
                        r_state        <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    // One NOP cycle lets the master return to idle.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign rdata   = r_rdata;
    assign M_CMD   = r_cmd;
    assign M_SADDR = r_saddr;
    assign M_WDATA = r_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Purpose:
//   Self-checking bench for apb_req_arbiter. It acts as a combined APB master
//   and slave on the observed bus. It predicts grant order, latency, done
//   timing, err and rdata from a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic               PCLK = 1'b0;
    logic               PRESET;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [DW-1:0]      rdata;
    logic [1:0]         M_CMD;
    logic [AW-1:0]      M_SADDR;
    logic [DW-1:0]      M_WDATA;
    logic               M_PSEL;
    logic               M_PENABLE;
    logic               M_PREADY;
    logic [DW-1:0]      M_PRDATA;

    apb_req_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .M_CMD     (M_CMD),
        .M_SADDR   (M_SADDR),
        .M_WDATA   (M_WDATA),
        .M_PSEL    (M_PSEL),
        .M_PENABLE (M_PENABLE),
        .M_PREADY  (M_PREADY),
        .M_PRDATA  (M_PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            model_last;
    logic [DW-1:0] exp_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Round-robin rule: first requesting index after the previous winner.
    function automatic int rr_pick(input logic [NREQ-1:0] pat, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (pat[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic rand_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_write[i]            = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW]    = $urandom();
            req_wdata[i*DW +: DW]   = $urandom();
        end
    endtask

    task automatic bus_idle();
        M_PSEL    = 1'b0;
        M_PENABLE = 1'b0;
        M_PREADY  = 1'b0;
    endtask

    function automatic logic [NREQ-1:0] rand_pat();
        logic [NREQ-1:0] p;
        p = '0;
        while (p == '0) p = NREQ'($urandom());
        return p;
    endfunction

    // One transaction: present pat (caller is at a negedge), expect gnt after
    // lat_exp edges, then run the slave with wt wait states in ACCESS.
    // With rst_mid, reset is asserted during ACCESS instead of completing.
    task automatic do_xfer(input logic [NREQ-1:0] pat, input int lat_exp, input int wt,
                           input logic [DW-1:0] prd, input bit rst_mid);
        int              lat;
        int              win;
        int              kd;
        bit              exp_err;
        logic            wr;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ew;
        logic [1:0]      ecmd;
        logic [NREQ-1:0] eg;

        req = pat;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge PCLK);
            if (gnt != '0) begin
                lat = n;
                break;
            end
            if (n == 1) check("done_pulse_width", done, '0);
        end
        if (lat == 0) begin
            check("gnt_seen", 0, 1);
            req = '0;
            return;
        end
        check("gnt_latency", lat, lat_exp);

        win        = rr_pick(pat, model_last);
        model_last = win;
        eg         = '0;
        eg[win]    = 1'b1;
        wr         = req_write[win];
        ea         = req_addr[win*AW +: AW];
        ew         = req_wdata[win*DW +: DW];
        ecmd       = wr ? 2'b10 : 2'b01;
        check("gnt", gnt, eg);
        check("cmd_at_gnt", M_CMD, ecmd);
        check("saddr_at_gnt", M_SADDR, ea);
        check("wdata_at_gnt", M_WDATA, ew);

        // Requester inputs changing during BUSY must have no effect.
        req = NREQ'($urandom());
        rand_reqs();

        M_PRDATA  = prd;
        M_PSEL    = 1'b1;
        M_PENABLE = 1'b0;
        M_PREADY  = 1'b0;
        kd        = (wt + 2 < TIMEOUT) ? wt + 2 : TIMEOUT;
        exp_err   = (wt + 2 > TIMEOUT);

        for (int k = 1; k <= kd; k++) begin
            @(negedge PCLK);
            if (rst_mid && k == 3) begin
                #2 PRESET = 1'b1;
                #1;
                check("rst_gnt", gnt, '0);
                check("rst_done", done, '0);
                check("rst_err", err, 1'b0);
                check("rst_rdata", rdata, '0);
                check("rst_cmd", M_CMD, 2'b00);
                check("rst_saddr", M_SADDR, '0);
                check("rst_wdata", M_WDATA, '0);
                bus_idle();
                req = '0;
                @(negedge PCLK);
                check("rst_no_done", done, '0);
                PRESET     = 1'b0;
                model_last = NREQ - 1;
                exp_rdata  = '0;
                return;
            end
            if (k < kd) begin
                check("busy_done", done, '0);
                check("busy_cmd", M_CMD, ecmd);
                check("busy_saddr", M_SADDR, ea);
                check("busy_wdata", M_WDATA, ew);
                M_PENABLE = 1'b1;
                M_PREADY  = (k - 1 == wt);
            end else begin
                if (!wr && !exp_err) exp_rdata = prd;
                check("done", done, eg);
                check("err", err, exp_err);
                check("rdata", rdata, exp_rdata);
                check("cmd_after_done", M_CMD, 2'b00);
                bus_idle();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] pat;
        int              wt;

        PRESET     = 1'b1;
        req        = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        M_PRDATA   = '0;
        bus_idle();
        model_last = NREQ - 1;
        exp_rdata  = '0;

        repeat (3) @(negedge PCLK);
        check("reset_gnt", gnt, '0);
        check("reset_done", done, '0);
        check("reset_err", err, 1'b0);
        check("reset_rdata", rdata, '0);
        check("reset_cmd", M_CMD, 2'b00);
        check("reset_saddr", M_SADDR, '0);
        check("reset_wdata", M_WDATA, '0);
        PRESET = 1'b0;

        // Idle with no request: no grant, command stays NOP.
        repeat (3) @(negedge PCLK);
        check("idle_gnt", gnt, '0);
        check("idle_cmd", M_CMD, 2'b00);

        // Single read, zero-wait slave.
        req_write[0]   = 1'b0;
        req_addr[0 +: AW] = 32'h0000_0040;
        do_xfer(4'b0001, 1, 0, 32'hDEAD_BEEF, 1'b0);

        // All requesters held: strict rotation.
        repeat (5) begin
            rand_reqs();
            do_xfer(4'b1111, 2, $urandom_range(0, 2), $urandom(), 1'b0);
        end

        // Write with three wait states.
        rand_reqs();
        req_write[2]          = 1'b1;
        req_addr[2*AW +: AW]  = 32'h0000_0100;
        req_wdata[2*DW +: DW] = 32'h1234_5678;
        do_xfer(4'b0100, 2, 3, $urandom(), 1'b0);

        // Timeout, then PREADY exactly on the timeout edge, then one past it.
        rand_reqs();
        req_write = '0;
        do_xfer(rand_pat(), 2, 40, $urandom(), 1'b0);
        rand_reqs();
        req_write = '0;
        do_xfer(rand_pat(), 2, TIMEOUT - 2, $urandom(), 1'b0);
        rand_reqs();
        req_write = '0;
        do_xfer(rand_pat(), 2, TIMEOUT - 1, $urandom(), 1'b0);

        // Randomized traffic; sometimes the previous pattern is held.
        pat = 4'b1111;
        for (int it = 0; it < 40; it++) begin
            rand_reqs();
            if ($urandom_range(0, 9) >= 3) pat = rand_pat();
            case ($urandom_range(0, 9))
                0:       wt = $urandom_range(TIMEOUT - 3, TIMEOUT + 4);
                1, 2:    wt = $urandom_range(5, 12);
                default: wt = $urandom_range(0, 3);
            endcase
            do_xfer(pat, 2, wt, $urandom(), 1'b0);
        end

        // Reset during ACCESS, then pointer back to NREQ-1.
        rand_reqs();
        do_xfer(rand_pat(), 2, 20, $urandom(), 1'b1);
        rand_reqs();
        do_xfer(4'b0011, 1, 1, $urandom(), 1'b0);

        repeat (2) @(negedge PCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
